// File: rtl/bcd_pkg.sv
// Shared BCD constants and FSM encoding for the binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W     = 4;
  localparam int unsigned BCD_MAX_DIGIT   = 9;
  localparam int unsigned BCD_ADD3_THRESH = 5;
  // Correction so that a digit >= 5 carries into the next digit after the shift.
  localparam int unsigned BCD_ADD3_VAL    =
    ((1 << BCD_DIGIT_W) - (BCD_MAX_DIGIT + 1)) / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_t;

endpackage

// File: rtl/bin2bcd_conv_if.sv
// Request/result bundle between a requester and the binary-to-BCD converter.
interface bin2bcd_conv_if
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                          start;
  logic [WIDTH-1:0]              bin;
  logic                          busy;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);

endinterface

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: add 3 to any digit of 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // 4-bit arithmetic only; no carry leaves the digit.
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= BCD_DIGIT_W'(BCD_ADD3_THRESH)) begin
      o_digit = i_digit + BCD_DIGIT_W'(BCD_ADD3_VAL);
    end
  end

endmodule

// File: rtl/bin2bcd_conv.sv
// Iterative binary-to-BCD converter, one double-dabble shift per clock.
module bin2bcd_conv
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bin2bcd_conv_if.slave        bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  bcd_state_t         r_state;
  bcd_state_t         w_next_state;
  logic [WIDTH-1:0]   r_bin;
  logic [BCD_W-1:0]   r_work;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W+WIDTH-1:0] w_shift;
  logic               w_last;

  // Correct every working digit in parallel before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The MSB of the corrected working register falls off; it is always 0 for legal DIGITS.
  assign w_shift = {w_adj, r_bin} << 1;
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      ST_SHIFT: bus.busy = 1'b1;
      ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture, shift/add-3 datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_bin  <= bus.bin;
            r_work <= '0;
            r_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          r_work <= w_shift[BCD_W+WIDTH-1:WIDTH];
          r_bin  <= w_shift[WIDTH-1:0];
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bcd <= w_shift[BCD_W+WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bcd = r_bcd;

endmodule

// File: doc/bin2bcd_conv.md
BIN2BCD_CONV -- requirements
Module: bin2bcd_conv

Interface
REQ-001 SHALL have parameter WIDTH, default 8, binary input width in bits.
REQ-002 SHALL have parameter DIGITS, default 3, number of BCD output digits; legal only if 10^DIGITS > 2^WIDTH - 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  input  1  conversion request; sampled only in IDLE.
REQ-006 SHALL have port bin  input  WIDTH  unsigned binary operand; captured on the edge that accepts start.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse; bcd holds the new result in that cycle.
REQ-009 SHALL have port bcd  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0], each digit 0-9; feeds the downstream BCD adder operands.

Function
REQ-010 SHALL implement the iterative shift-add-3 (double-dabble) algorithm, one shift per clock.
REQ-011 SHALL use FSM states IDLE, SHIFT and DONE.
REQ-012 IDLE: start=1 at an edge SHALL load bin into the binary shift register, clear the BCD working register and the shift counter, and go to SHIFT; start=0 SHALL stay in IDLE.
REQ-013 SHIFT: each edge SHALL add 3 to every working digit >= 5, then shift {working, binary} left one bit, then increment the counter.
REQ-014 SHIFT: on the edge that performs the WIDTH-th shift, the FSM SHALL copy the final working register into bcd and go to DONE.
REQ-015 DONE: done SHALL be 1 for exactly this one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-016 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH; the earliest next acceptance SHALL be edge k+WIDTH+2.
REQ-017 start in SHIFT or DONE SHALL be ignored; bin changes after capture SHALL NOT affect the result.
REQ-018 bcd SHALL change only on the REQ-014 edge and on reset, and SHALL hold its value between conversions.
REQ-019 Shift counter width SHALL be clog2(WIDTH+1); it SHALL NOT wrap within a conversion.
REQ-020 Add-3 correction SHALL use 4-bit arithmetic per digit with no carry between digits; digit values >= 10 SHALL never occur in the working register.
REQ-021 bin = 2^WIDTH - 1 SHALL convert without overflow of the top digit.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE with busy=0, done=0, bcd=0, counter=0 and working registers=0, including mid-conversion; the aborted conversion SHALL produce no done.
REQ-023 rst and start both high at an edge: reset SHALL win and start SHALL be dropped.

Structure
REQ-024 Shared package bcd_pkg SHALL hold BCD_DIGIT_W=4, BCD_MAX_DIGIT=9, the add-3 threshold constant 5 and the FSM state encoding type.
REQ-025 A sub-module bcd_add3 (4-bit in, 4-bit out: in>=5 ? in+3 : in) SHALL be instantiated once per digit via generate.
REQ-026 The block SHALL contain no latches; all outputs SHALL be registered or decoded from registered state only.

Verification
REQ-027 Reset, then bin=0 with a start pulse -> done after 8 shifts, bcd=12'h000, busy high for exactly 9 cycles.
REQ-028 bin=255 -> bcd=12'h255; bin=99 -> 12'h099; bin=100 -> 12'h100; bin=9 -> 12'h009.
REQ-029 Exhaustive 0..255: bcd digits equal the decimal digits of bin; done is one cycle wide every time.
REQ-030 start held high continuously with bin=37 -> done pulses every 10 cycles (WIDTH+2), bcd=12'h037 each time.
REQ-031 start with bin=200, bin changed to 15 and start pulsed again while busy -> result 12'h200; the second request is ignored.
REQ-032 rst asserted at the 4th shift of bin=123 -> next cycle busy=0, bcd=0, no done; a new start with bin=45 then gives 12'h045.
